// File: rtl/game_ctrl_if.sv
// Player-facing game signals: debounced start and hit pulses in, phase/score/timer out.
interface game_ctrl_if #(
  parameter int SCORE_W = 32
);
  logic               start;
  logic               hit;
  logic [1:0]         select;
  logic [SCORE_W-1:0] score;
  logic [5:0]         time_left;
  logic               sec_tick;

  modport master (output start, hit, input select, score, time_left, sec_tick);
  modport slave  (input start, hit, output select, score, time_left, sec_tick);
endinterface

// File: rtl/game_ctrl.sv
// Whack-a-mole round sequencer: idle -> playing -> over, second timer and hit score.
// state   | meaning
// IDLE    | waiting for a start edge; last score still shown
// PLAYING | round running, prescaler/timer active, hits counted
// OVER    | round finished, score and time_left frozen
// ILLEGAL | unreachable encoding, recovers to IDLE with reset values
module game_ctrl #(
  parameter int CLK_HZ       = 100000000,
  parameter int GAME_SECONDS = 35,
  parameter int SCORE_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  game_ctrl_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [5:0]    GS      = 6'(GAME_SECONDS);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAYING = 2'b01,
    OVER    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [5:0]         tl_q, tl_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick_q, tick_d;
  logic               start_q;
  logic               start_edge;

  assign start_edge = bus.start & ~start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      tl_q    <= GS;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      tl_q    <= tl_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      start_q <= bus.start;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    tl_d    = tl_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = PLAYING;
          score_d = '0;
          tl_d    = GS;
          pre_d   = '0;
        end
      end
      PLAYING: begin
        if (pre_q == PRE_MAX) begin
          pre_d  = '0;
          tick_d = 1'b1;
          tl_d   = tl_q - 6'd1;
          if (tl_q == 6'd1) state_d = OVER;
        end else begin
          pre_d = pre_q + PW'(1);
        end
        // saturate rather than wrap so a huge score never reads as zero
        if (bus.hit && (score_q != {SCORE_W{1'b1}})) score_d = score_q + SCORE_W'(1);
      end
      OVER: begin
        if (start_edge) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        score_d = '0;
        tl_d    = GS;
        pre_d   = '0;
      end
    endcase
  end

  assign bus.select    = state_q;
  assign bus.score     = score_q;
  assign bus.time_left = tl_q;
  assign bus.sec_tick  = tick_q;

endmodule
